// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial input, FIFO read/clear controls and receiver status outputs
//   slave : receiver side (serial_rx, rd_en, err_clr in; data, count, status out)
//   master: user side (drives serial_rx, rd_en, err_clr)
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                        serial_rx;
  logic                        rd_en;
  logic                        err_clr;
  logic [7:0]                  data_out;
  logic                        data_valid;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        busy;
  logic                        framing_err;
  logic                        parity_err;
  logic                        overrun_err;
  modport slave (
    input  serial_rx, rd_en, err_clr,
    output data_out, data_valid, fifo_count, busy, framing_err, parity_err, overrun_err
  );
  modport master (
    output serial_rx, rd_en, err_clr,
    input  data_out, data_valid, fifo_count, busy, framing_err, parity_err, overrun_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word fall-through FIFO
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : serial_rx/rd_en/err_clr in; data_out/data_valid/fifo_count/busy/sticky errors out
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 100000,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  uart_rx_fifo_if.slave bus
);
  localparam int DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DW  = $clog2(DIV + 1);
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [DW-1:0] DIV_END  = DW'(DIV - 1);
  localparam logic [OW-1:0] S0       = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] S1       = OW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] S2       = OW'(OVERSAMPLE / 2 + 1);
  localparam logic [OW-1:0] OS_END   = OW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t          r_state, w_next;
  logic [1:0]      r_sync;
  logic            r_rx_d;
  logic [DW-1:0]   r_div;
  logic [OW-1:0]   r_os;
  logic            r_s0, r_s1;
  logic [2:0]      r_bitcnt;
  logic            r_stopcnt;
  logic [7:0]      r_shift;
  logic            r_bad;
  logic            r_wr;
  logic [7:0]      r_wdata;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_cnt;
  logic            r_fe, r_pe, r_ov;
  logic            w_rx, w_fall, w_tick, w_mid, w_end, w_bit, w_last_stop, w_done;
  logic            w_pe_set, w_fe_set, w_ov_set, w_rd, w_wr;
  assign w_rx        = r_sync[1];
  assign w_fall      = r_rx_d & ~w_rx & (r_state == IDLE);
  assign w_tick      = (r_div == DIV_END) & (r_state != IDLE);
  assign w_mid       = w_tick & (r_os == S2);
  assign w_end       = w_tick & (r_os == OS_END);
  // the third sample is the live synchronised value at the deciding tick
  assign w_bit       = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_last_stop = (STOP_BITS == 1) | r_stopcnt;
  assign w_done      = (r_state == STOP) & w_mid & w_last_stop;
  assign w_pe_set    = (r_state == PAR) & w_mid & ((^{r_shift, w_bit}) != (PARITY == 1));
  assign w_fe_set    = (r_state == STOP) & w_mid & ~w_bit;
  assign w_rd        = bus.rd_en & (r_cnt != '0);
  // a full FIFO still accepts the byte when the same cycle pops the head
  assign w_wr        = r_wr & ((r_cnt != FULL) | w_rd);
  assign w_ov_set    = r_wr & (r_cnt == FULL) & ~w_rd;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = w_fall ? START : IDLE;
      START: w_next = (w_mid & w_bit) ? IDLE : w_end ? DATA : START;
      DATA:  w_next = (w_end & (r_bitcnt == LAST_BIT)) ? ((PARITY != 0) ? PAR : STOP) : DATA;
      PAR:   w_next = w_end ? STOP : PAR;
      STOP:  w_next = w_done ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync    <= 2'b11;
      r_rx_d    <= 1'b1;
      r_div     <= '0;
      r_os      <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_bitcnt  <= '0;
      r_stopcnt <= 1'b0;
      r_shift   <= '0;
      r_bad     <= 1'b0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
    end else begin
      r_sync <= {r_sync[0], bus.serial_rx};
      r_rx_d <= w_rx;
      r_div  <= (w_fall | (r_div == DIV_END)) ? '0 : r_div + 1'b1;
      r_os   <= w_fall ? '0 : w_tick ? ((r_os == OS_END) ? '0 : r_os + 1'b1) : r_os;
      if (w_tick & (r_os == S0)) r_s0 <= w_rx;
      if (w_tick & (r_os == S1)) r_s1 <= w_rx;
      if (w_fall) begin
        r_bitcnt  <= '0;
        r_stopcnt <= 1'b0;
        r_shift   <= '0;
        r_bad     <= 1'b0;
      end else begin
        if ((r_state == DATA) & w_mid) r_shift[r_bitcnt] <= w_bit;
        if ((r_state == DATA) & w_end) r_bitcnt <= r_bitcnt + 1'b1;
        if ((r_state == STOP) & w_end) r_stopcnt <= 1'b1;
        r_bad <= r_bad | w_pe_set | w_fe_set;
      end
      r_wr    <= w_done & ~r_bad & w_bit;
      r_wdata <= r_shift;
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= r_wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_fe  <= 1'b0;
      r_pe  <= 1'b0;
      r_ov  <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
      r_fe  <= w_fe_set | (r_fe & ~bus.err_clr);
      r_pe  <= w_pe_set | (r_pe & ~bus.err_clr);
      r_ov  <= w_ov_set | (r_ov & ~bus.err_clr);
    end
  assign bus.data_valid  = r_cnt != '0;
  assign bus.data_out    = bus.data_valid ? r_mem[r_rp] : '0;
  assign bus.fifo_count  = r_cnt;
  assign bus.busy        = r_state != IDLE;
  assign bus.framing_err = r_fe;
  assign bus.parity_err  = r_pe;
  assign bus.overrun_err = r_ov;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for three receiver configurations (8N1, 8E1, 7N2)
module tb_uart_rx_fifo;
  localparam int BT = 496;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx  = 3'b111;
  logic [2:0] rd  = 3'b000;
  logic [2:0] clr = 3'b000;
  int errors = 0;
  int checks = 0;
  logic [9:0] q[$];
  uart_rx_fifo_if if0 ();
  uart_rx_fifo_if if1 ();
  uart_rx_fifo_if if2 ();
  assign if0.serial_rx = rx[0];
  assign if1.serial_rx = rx[1];
  assign if2.serial_rx = rx[2];
  assign if0.rd_en     = rd[0];
  assign if1.rd_en     = rd[1];
  assign if2.rd_en     = rd[2];
  assign if0.err_clr   = clr[0];
  assign if1.err_clr   = clr[1];
  assign if2.err_clr   = clr[2];
  uart_rx_fifo dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  uart_rx_fifo #(.PARITY(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  uart_rx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  logic [7:0] w_dout [3];
  logic [2:0] w_cnt  [3];
  logic [2:0] w_valid, w_busy, w_fe, w_pe, w_ov;
  assign w_dout[0] = if0.data_out;
  assign w_dout[1] = if1.data_out;
  assign w_dout[2] = if2.data_out;
  assign w_cnt[0]  = if0.fifo_count;
  assign w_cnt[1]  = if1.fifo_count;
  assign w_cnt[2]  = if2.fifo_count;
  assign w_valid   = {if2.data_valid, if1.data_valid, if0.data_valid};
  assign w_busy    = {if2.busy, if1.busy, if0.busy};
  assign w_fe      = {if2.framing_err, if1.framing_err, if0.framing_err};
  assign w_pe      = {if2.parity_err, if1.parity_err, if0.parity_err};
  assign w_ov      = {if2.overrun_err, if1.overrun_err, if0.overrun_err};
  always #10 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic st(input int k, input string n, input int cnt, input logic v, input logic fe,
                    input logic pe, input logic ov);
    chk({n, "_count"}, 32'(w_cnt[k]), 32'(cnt));
    chk({n, "_valid"}, 32'(w_valid[k]), 32'(v));
    chk({n, "_ferr"}, 32'(w_fe[k]), 32'(fe));
    chk({n, "_perr"}, 32'(w_pe[k]), 32'(pe));
    chk({n, "_oerr"}, 32'(w_ov[k]), 32'(ov));
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bitx(input int k, input logic b);
    rx[k] = b;
    idle(BT);
  endtask
  task automatic send(input int k, input logic [7:0] d, input int nb, input int par,
                      input logic stopv, input int ns);
    bitx(k, 1'b0);
    for (int i = 0; i < nb; i++) bitx(k, d[i]);
    if (par >= 0) bitx(k, par[0]);
    for (int i = 0; i < ns; i++) bitx(k, stopv);
    rx[k] = 1'b1;
  endtask
  task automatic pop(input int k);
    @(posedge clk); #1 rd[k] = 1'b1;
    @(posedge clk); #1 rd[k] = 1'b0;
  endtask
  task automatic clear(input int k);
    @(posedge clk); #1 clr[k] = 1'b1;
    @(posedge clk); #1 clr[k] = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      if (rd[k] && w_valid[k]) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: dut%0d popped %0h with nothing expected", k, w_dout[k]);
        end else chk("mon_pop", {22'd0, 2'(k), w_dout[k]}, {22'd0, q.pop_front()});
      end
  end
  initial begin
    #15;
    for (int k = 0; k < 3; k++) begin
      st(k, "reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset_dout", 32'(w_dout[k]), 32'h0);
      chk("reset_busy", 32'(w_busy[k]), 32'h0);
    end
    @(negedge clk) rst = 1'b0;
    idle(5);
    q.push_back({2'd0, 8'hA5});
    send(0, 8'hA5, 8, -1, 1'b1, 1);
    idle(3);
    chk("a5_dout", 32'(w_dout[0]), 32'hA5);
    st(0, "a5", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    pop(0);
    chk("a5_valid_after_pop", 32'(w_valid[0]), 32'h0);
    rx[0] = 1'b0;
    idle(15);
    rx[0] = 1'b1;
    chk("glitch_busy", 32'(w_busy[0]), 32'h1);
    idle(BT + 100);
    chk("glitch_idle", 32'(w_busy[0]), 32'h0);
    st(0, "glitch", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1, 8'h07, 8, 0, 1'b1, 1);
    idle(3);
    st(1, "par_bad", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    clear(1);
    chk("par_clr", 32'(w_pe[1]), 32'h0);
    q.push_back({2'd1, 8'h07});
    send(1, 8'h07, 8, 1, 1'b1, 1);
    idle(3);
    chk("par_good_dout", 32'(w_dout[1]), 32'h07);
    st(1, "par_good", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    pop(1);
    send(0, 8'h3C, 8, -1, 1'b0, 1);
    idle(3);
    st(0, "frame_bad", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    q.push_back({2'd0, 8'h55});
    send(0, 8'h55, 8, -1, 1'b1, 1);
    idle(3);
    chk("frame_next_dout", 32'(w_dout[0]), 32'h55);
    pop(0);
    clear(0);
    chk("frame_clr", 32'(w_fe[0]), 32'h0);
    for (int i = 1; i <= 4; i++) q.push_back({2'd0, 8'(i)});
    for (int i = 1; i <= 5; i++) send(0, 8'(i), 8, -1, 1'b1, 1);
    idle(3);
    st(0, "overrun", 4, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pop(0);
    chk("drained_count", 32'(w_cnt[0]), 32'h0);
    pop(0);
    chk("empty_read_count", 32'(w_cnt[0]), 32'h0);
    q.push_back({2'd2, 8'h7F});
    send(2, 8'h7F, 7, -1, 1'b1, 2);
    idle(3);
    chk("7n2_dout", 32'(w_dout[2]), 32'h7F);
    st(2, "7n2", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    pop(2);
    q.push_back({2'd2, 8'h15});
    send(2, 8'h15, 7, -1, 1'b1, 2);
    bitx(2, 1'b0);
    bitx(2, 1'b1);
    rx[2] = 1'b0;
    idle(200);
    rst = 1'b1;
    #2;
    chk("rst_busy", 32'(w_busy[2]), 32'h0);
    chk("rst_dout", 32'(w_dout[2]), 32'h0);
    st(2, "rst_dut2", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_dut0_oerr", 32'(w_ov[0]), 32'h0);
    rx[2] = 1'b1;
    idle(3);
    @(negedge clk) rst = 1'b0;
    idle(2 * BT);
    chk("post_rst_busy", 32'(w_busy[2]), 32'h0);
    chk("post_rst_count", 32'(w_cnt[2]), 32'h0);
    q.push_front({2'd2, 8'h15});
    void'(q.pop_back());
    send(2, 8'h15, 7, -1, 1'b1, 2);
    idle(3);
    chk("resume_dout", 32'(w_dout[2]), 32'h15);
    pop(2);
    idle(2);
    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
